// File: rtl/audio_clken_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase-accumulator NCO
// feeding a half-period divider, with shadowed config applied at the 1->0 boundary.
module audio_clken_gen #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32,
  parameter int DIV_W  = 8
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] pend_o
);

  logic [7:0] pend_pad;
  logic       ch_in_range;
  logic       cfg_accept;

  // Pad pend to the full 3-bit channel space so out-of-range indices read as 0.
  always_comb begin
    pend_pad = '0;
    pend_pad[NUM_CH-1:0] = pend_o;
  end

  assign ch_in_range = ({1'b0, cfg_ch} < 4'(NUM_CH));
  assign cfg_ready   = ch_in_range ? !pend_pad[cfg_ch] : 1'b1;
  assign cfg_accept  = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_act;
    logic [ACC_W-1:0] inc_shd;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_shd;
    logic [DIV_W-1:0] divcnt;
    logic             pend_q;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             tc;
    logic             wr;

    assign sum   = {1'b0, acc} + {1'b0, inc_act};
    assign carry = sum[ACC_W];
    assign tc    = (divcnt == '0);
    assign wr    = cfg_accept && (cfg_ch == 3'(g));

    always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
        acc     <= '0;
        inc_act <= '0;
        inc_shd <= '0;
        div_act <= '0;
        div_shd <= '0;
        divcnt  <= '0;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        // A write is only accepted while pend is clear, so it never collides with an apply.
        if (wr) begin
          inc_shd <= cfg_inc;
          div_shd <= cfg_div;
          pend_q  <= 1'b1;
        end
        if (!ch_en[g]) begin
          acc    <= '0;
          clk_q  <= 1'b0;
          divcnt <= div_act;
          if (pend_q) begin
            inc_act <= inc_shd;
            div_act <= div_shd;
            divcnt  <= div_shd;
            pend_q  <= 1'b0;
          end
        end else begin
          acc <= sum[ACC_W-1:0];
          if (carry) begin
            if (!tc) begin
              divcnt <= divcnt - DIV_W'(1);
            end else begin
              clk_q  <= !clk_q;
              divcnt <= div_act;
              rise_q <= !clk_q;
              fall_q <= clk_q;
              // Period boundary: the falling toggle; acc keeps running for phase continuity.
              if (clk_q && pend_q) begin
                inc_act <= inc_shd;
                div_act <= div_shd;
                divcnt  <= div_shd;
                pend_q  <= 1'b0;
              end
            end
          end
        end
      end
    end

    assign clk_o[g]  = clk_q;
    assign rise_o[g] = rise_q;
    assign fall_o[g] = fall_q;
    assign pend_o[g] = pend_q;
  end

endmodule

// File: doc/audio_clken_gen.md
# audio_clken_gen

Multi-channel fractional clock-enable generator for the audio streaming path. It runs entirely in the PLL output domain and derives audio-rate timing from that single clock: bit clock, LR clock and sample strobes. Each channel uses a phase-accumulator NCO followed by an integer half-period divider. It produces a registered square wave plus one-cycle rise/fall enable pulses. Channels can be reprogrammed at run time; updates are glitch-free and take effect at the channel's period boundary.

## Interface

- NUM_CH, 2, number of independent channels (1..8)
- ACC_W, 32, phase accumulator / increment width
- DIV_W, 8, half-period divider width
- clkin  input  1  system clock (PLL CLKOUT domain)
- reset  input  1  asynchronous, active-high reset
- ch_en  input  NUM_CH  per-channel run enable
- cfg_valid  input  1  configuration write request
- cfg_ready  output  1  combinational; high when the addressed channel can accept a write
- cfg_ch  input  3  target channel index
- cfg_inc  input  ACC_W  NCO increment
- cfg_div  input  DIV_W  half-period divider value
- clk_o  output  NUM_CH  registered square wave; used as data or enable only, never as a clock
- rise_o  output  NUM_CH  one-cycle pulse in the cycle clk_o becomes 1
- fall_o  output  NUM_CH  one-cycle pulse in the cycle clk_o becomes 0
- pend_o  output  NUM_CH  shadow update pending, per channel

## Operation

- One clock domain, clkin. Reset is asynchronous and active-high.
- Per-channel state: acc[ACC_W], inc_act, inc_shd, div_act, div_shd, divcnt[DIV_W], pend, clk_o.
- Output frequency: f_clkin × inc / 2^ACC_W / (2 × (div+1)).
- **Reset:** every register clears to 0. All outputs are 0, and cfg_ready is 1.
- **Write handshake:**
  - A write is accepted on a clock edge where cfg_valid && cfg_ready.
  - cfg_ready = !pend[cfg_ch] when cfg_ch < NUM_CH, and 1 otherwise.
  - An out-of-range cfg_ch is accepted and dropped.
  - On accept: inc_shd ← cfg_inc, div_shd ← cfg_div, pend ← 1.
- **Disabled channel (ch_en=0):**
  - acc ← 0, divcnt ← div_act, clk_o ← 0. No pulses are emitted.
  - If pend is set: inc_act ← inc_shd, div_act ← div_shd, divcnt ← div_shd, pend ← 0 on the next edge.
- **Enabled channel:**
  - Each edge: {carry, acc} ← acc + inc_act, with wrap modulo 2^ACC_W.
  - On carry with divcnt ≠ 0: divcnt ← divcnt − 1.
  - On carry with divcnt = 0: toggle clk_o, divcnt ← div_act, and pulse rise_o or fall_o to match the new clk_o value.
- **Period boundary (1→0 toggle):**
  - If pend is set: inc_act ← inc_shd, div_act ← div_shd, divcnt ← div_shd, pend ← 0.
  - acc is not cleared, so phase stays continuous.
  - Updates never shorten or stretch the current high or low phase.
- **Boundary cases:**
  - inc_act = 0: acc never carries. clk_o holds its value and no pulses occur.
  - Increments near 2^ACC_W carry almost every cycle. At most one carry occurs per cycle.
  - div = 0: each half-period is one carry. div = 2^DIV_W − 1: each half-period is 2^DIV_W carries.
  - A write accepted in the same cycle as a period boundary goes only to the shadow registers. It applies at the next boundary, not the current one.
  - Deasserting ch_en mid-period: clk_o goes 0 on the next edge with no fall_o pulse. A pending update applies immediately.
  - Reasserting ch_en restarts from acc = 0 with clk_o = 0.
  - Reset mid-operation clears everything asynchronously. No pulses occur in that cycle.

## Timing

- Outputs clk_o, rise_o, fall_o and pend_o are registered. cfg_ready is the only combinational output.
- **First toggle after enable:** when ch_en is first sampled high at edge E0 with inc = 2^(ACC_W−1) and div = 0:
  - carry occurs at E1, so clk_o = 1 and rise_o = 1 after E1;
  - fall occurs after E3;
  - the period is 4 cycles at 50% duty.
- **rise_o / fall_o** are high for exactly one cycle, coincident with the first cycle of the new clk_o level.
- **pend_o** sets the cycle after accept. It clears the cycle after the applying boundary edge, or one edge later if the channel is disabled.
- **Throughput:** one write per channel per period. Writes to different channels can be back-to-back.

## Test plan

- **Reset values:** assert reset for 3 cycles with random inputs → all outputs 0 and cfg_ready = 1. Deassert → outputs stay 0 until a channel is enabled.
- **Integer divide:** ch0 inc = 0x8000_0000, div = 0, ch_en = 01.
  - Required: first rise after E1, then a rise every 4 cycles at 50% duty.
  - Check rise_o/fall_o: one per cycle, each coincident with its clk_o edge.
- **Fractional divide:** ch1 inc = 0x3000_0000, div = 0.
  - Required: exactly 3 rise_o pulses per 32 cycles over 320 cycles.
  - Required: high and low phases each last 5 or 6 cycles.
- **Live update:** ch0 running at inc = 0x8000_0000, div = 0; write div = 2 while clk_o = 1.
  - Required: cfg_ready for ch0 goes low.
  - Required: the current period completes with 2 cycles high and 2 low.
  - Required: subsequent periods are 12 cycles, with no runt pulse.
  - Required: pend_o[0] clears after the boundary.
- **Edge conditions:**
  - Out-of-range write with cfg_ch = 3 → accepted, no state change.
  - inc = 0 → clk_o never toggles.
  - Write in the boundary cycle → applied one period later.
- **Async reset mid-run:** pulse reset between edges while clk_o = 1 → all outputs 0 before the next clkin edge. After release, ch_en restart timing matches the Integer divide scenario.
